// File: rtl/fu_pkg.sv
// rtl/fu_pkg.sv - shared constants, state encoding and FS helpers for the fu sequencer
package fu_pkg;

    localparam int FU_NREG = 8;
    localparam int FU_W    = 16;

    localparam logic [3:0] FS_ADD   = 4'b0000;
    localparam logic [3:0] FS_PASSA = 4'b0001;
    localparam logic [3:0] FS_SUB   = 4'b0010;
    localparam logic [3:0] FS_NEGB  = 4'b0011;
    localparam logic [3:0] FS_BSUBA = 4'b0100;
    localparam logic [3:0] FS_NEGA  = 4'b0101;
    localparam logic [3:0] FS_NAND  = 4'b0110;
    localparam logic [3:0] FS_NOR   = 4'b0111;
    localparam logic [3:0] FS_NOTA  = 4'b1000;
    localparam logic [3:0] FS_MOD8  = 4'b1001;
    localparam logic [3:0] FS_DIV4  = 4'b1010;
    localparam logic [3:0] FS_CIRR  = 4'b1011;
    localparam logic [3:0] FS_CIRL  = 4'b1100;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RD   = 2'd1,
        ST_EX   = 2'd2,
        ST_WB   = 2'd3
    } state_t;

    // Arithmetic codes are the only ones whose V/C from the unit are meaningful.
    function automatic logic is_arith(input logic [3:0] fs);
        return (fs <= FS_NEGA);
    endfunction

    function automatic logic is_legal(input logic [3:0] fs);
        return (fs <= FS_CIRL);
    endfunction

endpackage

// File: rtl/fu_regfile_8x16.sv
// rtl/fu_regfile_8x16.sv - register file with muxed write port, two captured reads and a debug read
module fu_regfile_8x16
    import fu_pkg::*;
#(
    parameter int NREG = FU_NREG,
    parameter int W    = FU_W,
    parameter int AW   = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_ld_we,
    input  logic [AW-1:0] i_ld_addr,
    input  logic [W-1:0]  i_ld_data,
    input  logic          i_wb_we,
    input  logic [AW-1:0] i_wb_addr,
    input  logic [W-1:0]  i_wb_data,
    input  logic          i_rd_en,
    input  logic [AW-1:0] i_rd_addr_a,
    input  logic [AW-1:0] i_rd_addr_b,
    output logic [W-1:0]  o_rd_data_a,
    output logic [W-1:0]  o_rd_data_b,
    input  logic [AW-1:0] i_dbg_addr,
    output logic [W-1:0]  o_dbg_data
);

    logic [W-1:0]  r_mem [NREG];
    logic [W-1:0]  r_rd_a;
    logic [W-1:0]  r_rd_b;
    logic          w_we;
    logic [AW-1:0] w_waddr;
    logic [W-1:0]  w_wdata;

    // The sequencer never raises both sources in the same cycle; WB is given
    // the mux priority so a stray load can never corrupt a writeback.
    assign w_we    = i_wb_we | i_ld_we;
    assign w_waddr = i_wb_we ? i_wb_addr : i_ld_addr;
    assign w_wdata = i_wb_we ? i_wb_data : i_ld_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_mem[i] <= '0;
            end
            r_rd_a <= '0;
            r_rd_b <= '0;
        end else begin
            if (w_we) begin
                r_mem[w_waddr] <= w_wdata;
            end
            if (i_rd_en) begin
                r_rd_a <= r_mem[i_rd_addr_a];
                r_rd_b <= r_mem[i_rd_addr_b];
            end
        end
    end

    assign o_rd_data_a = r_rd_a;
    assign o_rd_data_b = r_rd_b;
    assign o_dbg_data  = r_mem[i_dbg_addr];

endmodule

// File: rtl/fu_sequencer.sv
// rtl/fu_sequencer.sv - IDLE/RD/EX/WB issue and writeback controller driving the 16-bit function unit
module fu_sequencer
    import fu_pkg::*;
#(
    parameter int NREG = FU_NREG,
    parameter int W    = FU_W
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         instr_valid,
    output logic         instr_ready,
    input  logic [3:0]   instr_fs,
    input  logic [2:0]   instr_dst,
    input  logic [2:0]   instr_srca,
    input  logic [2:0]   instr_srcb,
    input  logic         ld_valid,
    input  logic [2:0]   ld_addr,
    input  logic [W-1:0] ld_data,
    output logic [3:0]   fu_FS,
    output logic [W-1:0] fu_OpA,
    output logic [W-1:0] fu_OpB,
    input  logic [W-1:0] fu_result,
    input  logic         fu_V,
    input  logic         fu_C,
    input  logic         fu_N,
    input  logic         fu_Z,
    output logic         V,
    output logic         C,
    output logic         N,
    output logic         Z,
    output logic         done,
    output logic         err,
    input  logic [2:0]   dbg_addr,
    output logic [W-1:0] dbg_data
);

    state_t       r_state;
    state_t       w_next;

    logic [3:0]   r_fs;
    logic [2:0]   r_dst;
    logic [2:0]   r_srca;
    logic [2:0]   r_srcb;
    logic [3:0]   r_fu_fs;
    logic [W-1:0] r_res;
    logic         r_cap_v;
    logic         r_cap_c;
    logic         r_cap_n;
    logic         r_cap_z;
    logic         r_v;
    logic         r_c;
    logic         r_n;
    logic         r_z;
    logic         r_done;
    logic         r_err;

    logic         w_idle;
    logic         w_accept;
    logic         w_ld_we;
    logic         w_wb_we;
    logic         w_rd_en;
    logic         w_wb_legal;

    assign w_idle     = (r_state == ST_IDLE);
    assign w_accept   = w_idle && !ld_valid && instr_valid;
    assign w_ld_we    = w_idle && ld_valid;
    assign w_rd_en    = (r_state == ST_RD);
    assign w_wb_legal = is_legal(r_fs);
    assign w_wb_we    = (r_state == ST_WB) && w_wb_legal;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next      = r_state;
        instr_ready = 1'b0;
        case (r_state)
            ST_IDLE: begin
                instr_ready = !ld_valid;
                if (w_accept) begin
                    w_next = ST_RD;
                end
            end
            ST_RD:   w_next = ST_EX;
            ST_EX:   w_next = ST_WB;
            ST_WB:   w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_fs    <= FS_PASSA;
            r_dst   <= '0;
            r_srca  <= '0;
            r_srcb  <= '0;
            r_fu_fs <= FS_PASSA;
            r_res   <= '0;
            r_cap_v <= 1'b0;
            r_cap_c <= 1'b0;
            r_cap_n <= 1'b0;
            r_cap_z <= 1'b0;
            r_v     <= 1'b0;
            r_c     <= 1'b0;
            r_n     <= 1'b0;
            r_z     <= 1'b0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_fs   <= instr_fs;
                r_dst  <= instr_dst;
                r_srca <= instr_srca;
                r_srcb <= instr_srcb;
                if (is_legal(instr_fs)) begin
                    r_err <= 1'b0;
                end
            end
            // FS is only live for the EX cycle; pass-A keeps the unit quiet otherwise.
            r_fu_fs <= (w_next == ST_EX) ? r_fs : FS_PASSA;
            if (r_state == ST_EX) begin
                r_res   <= fu_result;
                r_cap_v <= fu_V;
                r_cap_c <= fu_C;
                r_cap_n <= fu_N;
                r_cap_z <= fu_Z;
            end
            r_done <= (w_next == ST_WB);
            if (r_state == ST_WB) begin
                if (w_wb_legal) begin
                    r_n   <= r_cap_n;
                    r_z   <= r_cap_z;
                    r_v   <= is_arith(r_fs) ? r_cap_v : 1'b0;
                    r_c   <= is_arith(r_fs) ? r_cap_c : 1'b0;
                    r_err <= 1'b0;
                end else begin
                    r_err <= 1'b1;
                end
            end
        end
    end

    // Operand registers inside the regfile double as the fu_OpA/fu_OpB drivers.
    fu_regfile_8x16 #(
        .NREG (NREG),
        .W    (W)
    ) u_regfile (
        .clk         (clk),
        .reset       (reset),
        .i_ld_we     (w_ld_we),
        .i_ld_addr   (ld_addr),
        .i_ld_data   (ld_data),
        .i_wb_we     (w_wb_we),
        .i_wb_addr   (r_dst),
        .i_wb_data   (r_res),
        .i_rd_en     (w_rd_en),
        .i_rd_addr_a (r_srca),
        .i_rd_addr_b (r_srcb),
        .o_rd_data_a (fu_OpA),
        .o_rd_data_b (fu_OpB),
        .i_dbg_addr  (dbg_addr),
        .o_dbg_data  (dbg_data)
    );

    assign fu_FS = r_fu_fs;
    assign V     = r_v;
    assign C     = r_c;
    assign N     = r_n;
    assign Z     = r_z;
    assign done  = r_done;
    assign err   = r_err;

endmodule

// File: tb/tb_fu_sequencer.sv
// tb/tb_fu_sequencer.sv - scoreboard bench for fu_sequencer with a behavioural function unit attached
module tb_fu_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        instr_valid;
    logic        instr_ready;
    logic [3:0]  instr_fs;
    logic [2:0]  instr_dst;
    logic [2:0]  instr_srca;
    logic [2:0]  instr_srcb;
    logic        ld_valid;
    logic [2:0]  ld_addr;
    logic [15:0] ld_data;
    logic [3:0]  fu_FS;
    logic [15:0] fu_OpA;
    logic [15:0] fu_OpB;
    logic [15:0] fu_result;
    logic        fu_V, fu_C, fu_N, fu_Z;
    logic        V, C, N, Z;
    logic        done;
    logic        err;
    logic [2:0]  dbg_addr;
    logic [15:0] dbg_data;

    always #5 clk = ~clk;

    fu_sequencer dut (
        .clk         (clk),
        .reset       (reset),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_fs    (instr_fs),
        .instr_dst   (instr_dst),
        .instr_srca  (instr_srca),
        .instr_srcb  (instr_srcb),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_data     (ld_data),
        .fu_FS       (fu_FS),
        .fu_OpA      (fu_OpA),
        .fu_OpB      (fu_OpB),
        .fu_result   (fu_result),
        .fu_V        (fu_V),
        .fu_C        (fu_C),
        .fu_N        (fu_N),
        .fu_Z        (fu_Z),
        .V           (V),
        .C           (C),
        .N           (N),
        .Z           (Z),
        .done        (done),
        .err         (err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    // Function unit: returns {V, C, N, Z, result}. Logic/shift and illegal codes
    // deliberately report V=C=1 so the sequencer's forcing is observable.
    function automatic logic [19:0] fu_eval(input logic [3:0] fs, input logic [15:0] a,
                                            input logic [15:0] b);
        logic [16:0] s;
        logic [15:0] r;
        logic        v;
        logic        c;
        s = '0;
        r = '0;
        v = 1'b1;
        c = 1'b1;
        case (fs)
            4'd0: begin
                s = {1'b0, a} + {1'b0, b};
                r = s[15:0]; c = s[16]; v = (a[15] == b[15]) && (r[15] != a[15]);
            end
            4'd1: begin r = a; c = 1'b0; v = 1'b0; end
            4'd2: begin
                s = {1'b0, a} + {1'b0, ~b} + 17'd1;
                r = s[15:0]; c = s[16]; v = (a[15] != b[15]) && (r[15] != a[15]);
            end
            4'd3: begin
                s = {1'b0, ~b} + 17'd1;
                r = s[15:0]; c = s[16]; v = (b == 16'h8000);
            end
            4'd4: begin
                s = {1'b0, b} + {1'b0, ~a} + 17'd1;
                r = s[15:0]; c = s[16]; v = (a[15] != b[15]) && (r[15] != b[15]);
            end
            4'd5: begin
                s = {1'b0, ~a} + 17'd1;
                r = s[15:0]; c = s[16]; v = (a == 16'h8000);
            end
            4'd6:    r = ~(a & b);
            4'd7:    r = ~(a | b);
            4'd8:    r = ~a;
            4'd9:    r = {13'd0, a[2:0]};
            4'd10:   r = a >> 2;
            4'd11:   r = {a[0], a[15:1]};
            4'd12:   r = {a[14:0], a[15]};
            default: r = 16'hDEAD;
        endcase
        return {v, c, r[15], (r == 16'h0000), r};
    endfunction

    always_comb begin
        {fu_V, fu_C, fu_N, fu_Z, fu_result} = fu_eval(fu_FS, fu_OpA, fu_OpB);
    end

    typedef struct {
        logic [2:0]  dst;
        logic [15:0] res;
        logic        v, c, n, z, err;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] sh[8];
    logic        sh_v, sh_c, sh_n, sh_z, sh_err;
    int          n_pass  = 0;
    int          n_total = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic shadow_reset();
        for (int i = 0; i < 8; i++) sh[i] = 16'h0000;
        sh_v = 1'b0; sh_c = 1'b0; sh_n = 1'b0; sh_z = 1'b0; sh_err = 1'b0;
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbg_addr = 3'(i);
            #1;
            check_eq($sformatf("%s_r%0d", tag, i), {16'd0, dbg_data}, {16'd0, sh[i]});
        end
        check_eq({tag, "_flags"}, {27'd0, V, C, N, Z, err}, {27'd0, sh_v, sh_c, sh_n, sh_z, sh_err});
    endtask

    task automatic read_reg(input logic [2:0] a, output logic [15:0] d);
        dbg_addr = a;
        #1;
        d = dbg_data;
    endtask

    task automatic do_load(input logic [2:0] a, input logic [15:0] d);
        logic [15:0] rd;
        @(negedge clk);
        ld_valid = 1'b1; ld_addr = a; ld_data = d;
        @(posedge clk);
        sh[a] = d;
        @(negedge clk);
        ld_valid = 1'b0;
        read_reg(a, rd);
        check_eq("load", {16'd0, rd}, {16'd0, d});
    endtask

    // mode: 0 plain, 1 load contends with the offer, 2 loads driven while busy, 3 reset during EX
    task automatic issue(input logic [3:0] fs, input logic [2:0] dst, input logic [2:0] sa,
                         input logic [2:0] sb_r, input int mode);
        exp_t        e;
        logic        rdy;
        logic        accepted;
        logic [19:0] f;
        logic [15:0] opa, opb, rd;
        @(negedge clk);
        instr_valid = 1'b1; instr_fs = fs; instr_dst = dst; instr_srca = sa; instr_srcb = sb_r;
        if (mode == 1) begin
            ld_valid = 1'b1; ld_addr = sa; ld_data = 16'h1234;
            #1;
            check_eq("ready_with_ld", {31'd0, instr_ready}, 32'd0);
            @(posedge clk);
            sh[sa] = 16'h1234;
            @(negedge clk);
            ld_valid = 1'b0;
        end
        accepted = 1'b0;
        for (int k = 0; k < 20 && !accepted; k++) begin
            if (k > 0) @(negedge clk);
            #1;
            rdy = instr_ready;
            @(posedge clk);
            accepted = rdy;
        end
        if (!accepted) begin
            check_eq("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            return;
        end
        opa = sh[sa];
        opb = sh[sb_r];
        f   = fu_eval(fs, opa, opb);
        e.dst = dst;
        if (fs <= 4'd12) begin
            e.res = f[15:0];
            e.n   = f[17];
            e.z   = f[16];
            e.v   = (fs <= 4'd5) ? f[19] : 1'b0;
            e.c   = (fs <= 4'd5) ? f[18] : 1'b0;
            e.err = 1'b0;
            sh[dst] = e.res;
            sh_v = e.v; sh_c = e.c; sh_n = e.n; sh_z = e.z; sh_err = 1'b0;
        end else begin
            e.res = sh[dst];
            e.v = sh_v; e.c = sh_c; e.n = sh_n; e.z = sh_z; e.err = 1'b1;
            sh_err = 1'b1;
        end
        sb.push_back(e);

        @(negedge clk);
        instr_valid = 1'b0;
        check_eq("fs_rd_passa", {28'd0, fu_FS}, 32'd1);
        if (mode == 2) begin
            ld_valid = 1'b1; ld_addr = 3'($urandom_range(0, 7)); ld_data = 16'($urandom);
        end
        @(negedge clk);
        check_eq("fs_ex", {28'd0, fu_FS}, {28'd0, fs});
        check_eq("opa_ex", {16'd0, fu_OpA}, {16'd0, opa});
        check_eq("opb_ex", {16'd0, fu_OpB}, {16'd0, opb});
        if (mode == 3) begin
            reset = 1'b1;
            @(posedge clk);
            @(negedge clk);
            reset = 1'b0;
            void'(sb.pop_back());
            shadow_reset();
            return;
        end
        @(negedge clk);
        check_eq("done_at_wb", {31'd0, done}, 32'd1);
        ld_valid = 1'b0;
        @(negedge clk);
        check_eq("done_one_cycle", {31'd0, done}, 32'd0);
        check_eq("ready_after_wb", {31'd0, instr_ready}, 32'd1);
        if (sb.size() == 0) begin
            check_eq("sb_empty", 32'd0, 32'd1);
            return;
        end
        e = sb.pop_front();
        check_eq("flags_vcnz", {28'd0, V, C, N, Z}, {28'd0, e.v, e.c, e.n, e.z});
        check_eq("err", {31'd0, err}, {31'd0, e.err});
        read_reg(e.dst, rd);
        check_eq("wb_data", {16'd0, rd}, {16'd0, e.res});
    endtask

    initial begin
        logic [15:0] rd;
        reset = 1'b1; instr_valid = 1'b0; instr_fs = '0; instr_dst = '0; instr_srca = '0;
        instr_srcb = '0; ld_valid = 1'b0; ld_addr = '0; ld_data = '0; dbg_addr = '0;
        shadow_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check_eq("rst_done", {31'd0, done}, 32'd0);
        check_eq("rst_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("rst_fs", {28'd0, fu_FS}, 32'd1);
        check_eq("rst_ops", {fu_OpA, fu_OpB}, 32'd0);
        check_all("rst");

        do_load(3'd1, 16'h7FFF);
        do_load(3'd2, 16'h0001);
        issue(4'b0000, 3'd3, 3'd1, 3'd2, 0);
        read_reg(3'd3, rd);
        check_eq("add_r3", {16'd0, rd}, 32'h8000);
        check_eq("add_vcnz", {28'd0, V, C, N, Z}, 32'b1010);

        do_load(3'd4, 16'h0005);
        issue(4'b0010, 3'd5, 3'd4, 3'd4, 0);
        read_reg(3'd5, rd);
        check_eq("sub_r5", {16'd0, rd}, 32'h0000);
        check_eq("sub_vcnz", {28'd0, V, C, N, Z}, 32'b0101);

        do_load(3'd1, 16'h00F0);
        do_load(3'd2, 16'h0FF0);
        issue(4'b0110, 3'd6, 3'd1, 3'd2, 0);
        read_reg(3'd6, rd);
        check_eq("nand_r6", {16'd0, rd}, 32'hFF0F);
        check_eq("nand_vcnz", {28'd0, V, C, N, Z}, 32'b0010);

        issue(4'b1110, 3'd3, 3'd1, 3'd2, 0);
        read_reg(3'd3, rd);
        check_eq("illegal_r3", {16'd0, rd}, 32'h8000);
        check_eq("illegal_err", {31'd0, err}, 32'd1);
        check_eq("illegal_vcnz", {28'd0, V, C, N, Z}, 32'b0010);
        issue(4'b0000, 3'd0, 3'd1, 3'd2, 0);
        check_eq("err_cleared", {31'd0, err}, 32'd0);

        issue(4'b0001, 3'd7, 3'd4, 3'd0, 1);
        read_reg(3'd7, rd);
        check_eq("ld_then_pass", {16'd0, rd}, 32'h1234);
        check_all("directed");

        for (int i = 0; i < 24; i++) begin
            issue(4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)),
                  3'($urandom_range(0, 7)), int'($urandom_range(0, 2)));
        end
        check_all("random");

        do_load(3'd1, 16'h7FFF);
        do_load(3'd2, 16'h0001);
        issue(4'b0000, 3'd3, 3'd1, 3'd2, 3);
        #1;
        check_eq("abort_ready", {31'd0, instr_ready}, 32'd1);
        check_eq("abort_done", {31'd0, done}, 32'd0);
        check_all("abort");
        @(negedge clk);
        check_eq("abort_no_late_done", {31'd0, done}, 32'd0);
        check_all("abort_later");

        issue(4'b0000, 3'd3, 3'd1, 3'd2, 0);
        check_eq("post_abort_z", {31'd0, Z}, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
